eth_tx_arbiter: RTL and testbench

Two-input, frame-granular AXI-Stream arbiter that shares the single 64-bit 10G TX stream between two frame sources (e.g. loopback bridge and a local packet generator) in the clk156 domain. A grant is held from the first beat of a frame until its tlast beat handshakes, so frames never interleave. Round-robin between sources by default. Per-source frame counters support monitoring.

---
 rtl/eth_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// eth_tx_arbiter : frame-granular 2:1 AXI-Stream arbiter for the 10G TX path.
// Build option ETH_TX_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
// Revision: 1.0
// ============================================================================
module eth_tx_arbiter #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                clk156,
  input  logic                rst,

  input  logic                s0_axis_tvalid,
  input  logic [DATA_W-1:0]   s0_axis_tdata,
  input  logic [DATA_W/8-1:0] s0_axis_tkeep,
  input  logic                s0_axis_tlast,
  input  logic                s0_axis_tuser,
  output logic                s0_axis_tready,

  input  logic                s1_axis_tvalid,
  input  logic [DATA_W-1:0]   s1_axis_tdata,
  input  logic [DATA_W/8-1:0] s1_axis_tkeep,
  input  logic                s1_axis_tlast,
  input  logic                s1_axis_tuser,
  output logic                s1_axis_tready,

  input  logic                m_axis_tx_tready,
  output logic                m_axis_tx_tvalid,
  output logic [DATA_W-1:0]   m_axis_tx_tdata,
  output logic [DATA_W/8-1:0] m_axis_tx_tkeep,
  output logic                m_axis_tx_tlast,
  output logic                m_axis_tx_tuser,

  output logic [CNT_W-1:0]    frame_cnt0,
  output logic [CNT_W-1:0]    frame_cnt1,
  output logic                busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic             r_sel, w_sel_nxt;
  logic             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_cnt0, w_cnt0_nxt;
  logic [CNT_W-1:0] r_cnt1, w_cnt1_nxt;
  logic             w_pick;
  logic             w_hs;

  // Winner for the next grant, evaluated only while idle.
  always_comb begin
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
    w_pick = ~s0_axis_tvalid;
`else
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      w_pick = ~r_last;
    end else begin
      w_pick = ~s0_axis_tvalid;
    end
`endif
  end

  always_ff @(posedge clk156) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt0  <= w_cnt0_nxt;
      r_cnt1  <= w_cnt1_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_last_nxt       = r_last;
    w_cnt0_nxt       = r_cnt0;
    w_cnt1_nxt       = r_cnt1;
    w_hs             = 1'b0;
    s0_axis_tready   = 1'b0;
    s1_axis_tready   = 1'b0;
    m_axis_tx_tvalid = 1'b0;
    m_axis_tx_tdata  = '0;
    m_axis_tx_tkeep  = '0;
    m_axis_tx_tlast  = 1'b0;
    m_axis_tx_tuser  = 1'b0;

    case (r_state)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_pick;
          w_last_nxt  = w_pick;
        end
      end
      GRANT: begin
        // Pure combinational pass-through; the grant persists across source gaps.
        if (r_sel) begin
          m_axis_tx_tvalid = s1_axis_tvalid;
          m_axis_tx_tdata  = s1_axis_tdata;
          m_axis_tx_tkeep  = s1_axis_tkeep;
          m_axis_tx_tlast  = s1_axis_tlast;
          m_axis_tx_tuser  = s1_axis_tuser;
          s1_axis_tready   = m_axis_tx_tready;
        end else begin
          m_axis_tx_tvalid = s0_axis_tvalid;
          m_axis_tx_tdata  = s0_axis_tdata;
          m_axis_tx_tkeep  = s0_axis_tkeep;
          m_axis_tx_tlast  = s0_axis_tlast;
          m_axis_tx_tuser  = s0_axis_tuser;
          s0_axis_tready   = m_axis_tx_tready;
        end
        w_hs = m_axis_tx_tvalid && m_axis_tx_tready;
        if (w_hs && m_axis_tx_tlast) begin
          w_state_nxt = IDLE;
          if (r_sel) begin
            w_cnt1_nxt = r_cnt1 + c_cnt_one;
          end else begin
            w_cnt0_nxt = r_cnt0 + c_cnt_one;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign frame_cnt0 = r_cnt0;
  assign frame_cnt1 = r_cnt1;
  assign busy       = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_eth_tx_arbiter : randomized bench for eth_tx_arbiter with reference model.
// Revision: 1.0
// ============================================================================
module tb_eth_tx_arbiter;

  localparam int DATA_W = 64;
  localparam int KEEP_W = DATA_W/8;
  localparam int CNT_W  = 8;  // narrow counters keep the wrap scenario short
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              user;
  } beat_t;

  logic              clk156 = 1'b0;
  logic              rst    = 1'b1;
  logic              sv   [2];
  beat_t             sb   [2];
  logic              srdy [2];
  logic              mrdy;
  logic              mv, ml, mu, busy;
  logic [DATA_W-1:0] md;
  logic [KEEP_W-1:0] mk;
  logic [CNT_W-1:0]  c0, c1;

  eth_tx_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk156(clk156), .rst(rst),
    .s0_axis_tvalid(sv[0]), .s0_axis_tdata(sb[0].data), .s0_axis_tkeep(sb[0].keep),
    .s0_axis_tlast(sb[0].last), .s0_axis_tuser(sb[0].user), .s0_axis_tready(srdy[0]),
    .s1_axis_tvalid(sv[1]), .s1_axis_tdata(sb[1].data), .s1_axis_tkeep(sb[1].keep),
    .s1_axis_tlast(sb[1].last), .s1_axis_tuser(sb[1].user), .s1_axis_tready(srdy[1]),
    .m_axis_tx_tready(mrdy), .m_axis_tx_tvalid(mv), .m_axis_tx_tdata(md),
    .m_axis_tx_tkeep(mk), .m_axis_tx_tlast(ml), .m_axis_tx_tuser(mu),
    .frame_cnt0(c0), .frame_cnt1(c1), .busy(busy)
  );

  always #3 clk156 = ~clk156;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t q0[$];
  beat_t q1[$];
  int    done[$];
  int    owner = -1;    // source currently owning the TX stream, -1 = none
  int    prev  = 1;     // source that won the most recent arbitration
  int    ecnt [2];
  int    hold [2];
  int    gap_pct = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: 1010 toggle, 2: random
  bit    tog = 1'b1;
  bit    rst_req = 1'b1;
  int    exp_order [4];
  int    rs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 1) ? q1.size() : q0.size();
  endfunction

  function automatic beat_t head(input int s);
    return (s == 1) ? q1[0] : q0[0];
  endfunction

  function automatic beat_t rand_beat();
    beat_t   b;
    logic [31:0] r;
    r      = $urandom;
    b.data = {$urandom, $urandom};
    b.keep = r[7:0];
    b.last = r[8];
    b.user = r[9];
    return b;
  endfunction

  task automatic add_frame(input int s, input int n, input logic [KEEP_W-1:0] last_keep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b      = rand_beat();
      b.keep = (i == n-1) ? last_keep : '1;
      b.last = (i == n-1);
      if (s == 1) q1.push_back(b); else q0.push_back(b);
    end
  endtask

  task automatic drive();
    rst = rst_req;
    for (int s = 0; s < 2; s++) begin
      if (hold[s] > 0) begin
        sv[s] = 1'b0;
        sb[s] = rand_beat();
        hold[s]--;
      end else if (qsize(s) > 0 && $urandom_range(99) >= gap_pct) begin
        sv[s] = 1'b1;
        sb[s] = head(s);
      end else begin
        sv[s] = 1'b0;
        sb[s] = rand_beat();
      end
    end
    case (rdy_mode)
      0:       mrdy = 1'b1;
      1:       begin mrdy = tog; tog = ~tog; end
      default: mrdy = 1'($urandom_range(1));
    endcase
  endtask

  // Expected outputs follow from who owns the stream this cycle.
  task automatic check_cycle();
    beat_t      e;
    logic       ev;
    logic [1:0] er;
    e  = '0;
    ev = 1'b0;
    er = 2'b00;
    if (owner >= 0) begin
      e         = sb[owner];
      ev        = sv[owner];
      er[owner] = mrdy;
    end
    check("busy",       busy,    owner >= 0);
    check("s0_tready",  srdy[0], er[0]);
    check("s1_tready",  srdy[1], er[1]);
    check("m_tvalid",   mv,      ev);
    check("m_tdata",    md,      e.data);
    check("m_tkeep",    mk,      e.keep);
    check("m_tlast",    ml,      e.last);
    check("m_tuser",    mu,      e.user);
    check("frame_cnt0", c0,      ecnt[0]);
    check("frame_cnt1", c1,      ecnt[1]);
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      owner = -1; prev = 1; ecnt[0] = 0; ecnt[1] = 0;
      hold[0] = 0; hold[1] = 0;
      q0.delete(); q1.delete();
    end else begin
      if (owner < 0) begin
        w = -1;
        if (sv[0] && sv[1])  w = FIXED ? 0 : 1 - prev;
        else if (sv[0])      w = 0;
        else if (sv[1])      w = 1;
        if (w >= 0) begin owner = w; prev = w; end
      end else if (sv[owner] && mrdy && sb[owner].last) begin
        ecnt[owner] = (ecnt[owner] + 1) % (1 << CNT_W);
        done.push_back(owner);
        owner = -1;
      end
      if (sv[0] && srdy[0]) void'(q0.pop_front());
      if (sv[1] && srdy[1]) void'(q1.pop_front());
    end
  endtask

  task automatic cycle();
    @(posedge clk156);
    #1;
    drive();
    @(negedge clk156);
    check_cycle();
    model_step();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || owner >= 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("timeout", 1, 0);
    cycle();
  endtask

  task automatic reset_pulse();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
  endtask

  initial begin
    sv[0] = 1'b0; sv[1] = 1'b0;
    sb[0] = '0;   sb[1] = '0;
    mrdy  = 1'b0;
    ecnt[0] = 0; ecnt[1] = 0;
    hold[0] = 0; hold[1] = 0;

    // Reset state
    repeat (3) cycle();
    rst_req = 1'b0;

    // Single 3-beat frame on source 0
    add_frame(0, 3, 8'h0F);
    run_until_idle(50);
    check("single_cnt0", c0, 1);

    // Contention from reset release, two frames per source
    reset_pulse();
    done.delete();
    add_frame(0, $urandom_range(1, 4), 8'hFF);
    add_frame(0, $urandom_range(1, 4), 8'h03);
    add_frame(1, $urandom_range(1, 4), 8'h7F);
    add_frame(1, $urandom_range(1, 4), 8'h01);
    run_until_idle(100);
    exp_order = FIXED ? '{0, 0, 1, 1} : '{0, 1, 0, 1};
    check("order_len", done.size(), 4);
    for (int i = 0; i < 4 && i < done.size(); i++) check("order", done[i], exp_order[i]);

    // Backpressure 1010 on an s1 frame with s0 waiting
    rdy_mode = 1; tog = 1'b1;
    add_frame(1, 4, 8'h3F);
    cycle();
    add_frame(0, 3, 8'hFF);
    run_until_idle(100);
    rdy_mode = 0;

    // Granted source gaps for two cycles while the other is waiting
    add_frame(0, 5, 8'h1F);
    cycle();
    cycle();
    add_frame(1, 2, 8'hFF);
    hold[0] = 2;
    run_until_idle(100);

    // Random traffic, gaps and backpressure
    rdy_mode = 2; gap_pct = 25;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        rs = $urandom_range(1);
        if (qsize(rs) < 12) add_frame(rs, $urandom_range(1, 6), 8'($urandom));
      end
      cycle();
    end
    gap_pct = 0;
    run_until_idle(2000);
    rdy_mode = 0;

    // Reset on beat 2 of a 4-beat frame
    add_frame(0, 4, 8'hFF);
    cycle();
    cycle();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    check("rst_cnt0", c0, 0);
    check("rst_busy", busy, 0);
    add_frame(0, 2, 8'h0F);
    run_until_idle(50);
    check("post_rst_cnt0", c0, 1);

    // Counter wrap on source 1
    reset_pulse();
    done.delete();
    for (int i = 0; i < (1 << CNT_W); i++) add_frame(1, 1, 8'hFF);
    run_until_idle(4 * (1 << CNT_W) + 100);
    check("wrap_frames", done.size(), 1 << CNT_W);
    check("wrap_cnt1", c1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
